// File: rtl/xs3_serial_adder.sv
// ---------------------------------------------------------------------------
// xs3_serial_adder
//
// Digit-serial excess-3 adder. One pair of XS-3 digits is accepted per input
// handshake, least-significant digit first; one XS-3 sum digit is produced per
// output beat, one cycle after acceptance. The decimal carry is held between
// digits of a number and discarded after the in_last digit.
//
// Optional feature (macro XS3_CARRY_DIGIT_EN): a final digit that produces a
// carry is followed by an extra output digit "1" (4'b0100). err/ovf move to
// that extra beat and input is stalled until it has been taken.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Producers hold their fields stable while valid && !ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input digit-pair handshake
//   in_a, in_b           operand digits (XS-3)
//   in_last              pair is the most-significant digit of the number
//   out_valid/out_ready  output digit handshake
//   out_sum              sum digit (XS-3)
//   out_last             final digit of the number
//   out_carry            decimal carry out of the final digit (with out_last)
//   err                  invalid XS-3 code seen in this number (with out_last)
//   ovf                  number longer than NDIG digits (with out_last)
// ---------------------------------------------------------------------------
module xs3_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_last,
    output logic       out_carry,
    output logic       err,
    output logic       ovf
);

    localparam int CW = $clog2(NDIG + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CDIG = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     out_sum_q, out_sum_d;
    logic           out_last_q, out_last_d;
    logic           out_carry_q, out_carry_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sticky_q, sticky_d;
`ifdef XS3_CARRY_DIGIT_EN
    // err/ovf of a carrying number, parked until the extra digit is emitted.
    logic           pend_err_q, pend_err_d;
    logic           pend_ovf_q, pend_ovf_d;
`endif

    logic [4:0]     t;
    logic           cout;
    logic [3:0]     sum;
    logic [CW-1:0]  cnt_inc;
    logic           num_ovf;
    logic           cur_err;
    logic           acc;

    function automatic logic bad_code(input logic [3:0] c);
        return (c < 4'd3) || (c > 4'd12);
    endfunction

    assign in_ready  = (state_q != CDIG) && (!out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

    always_comb begin
        // Raw binary sum of two XS-3 codes carries an excess of 6; correct by
        // -3 when no decimal carry, or +3 (after dropping 16) when carrying.
        t       = {1'b0, in_a} + {1'b0, in_b} + 5'(carry_q);
        cout    = t[4];
        sum     = cout ? (t[3:0] + 4'd3) : (t[3:0] - 4'd3);
        cnt_inc = (cnt_q == CW'(NDIG + 1)) ? cnt_q : (cnt_q + CW'(1));
        num_ovf = (cnt_inc > CW'(NDIG));
        cur_err = bad_code(in_a) || bad_code(in_b);

        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
`ifdef XS3_CARRY_DIGIT_EN
        pend_err_d  = pend_err_q;
        pend_ovf_d  = pend_ovf_q;
`endif

        if (state_q == CDIG) begin
`ifdef XS3_CARRY_DIGIT_EN
            if (out_valid_q && out_ready) begin
                if (out_last_q) begin
                    // Extra digit taken: number complete.
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    // Carrying digit taken: present the extra "1" digit.
                    out_valid_d = 1'b1;
                    out_sum_d   = 4'b0100;
                    out_last_d  = 1'b1;
                    out_carry_d = 1'b0;
                    err_d       = pend_err_q;
                    ovf_d       = pend_ovf_q;
                end
            end
`endif
        end else if (acc) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_last_d  = in_last;
            out_carry_d = in_last && cout;
            err_d       = in_last && (sticky_q || cur_err);
            ovf_d       = in_last && num_ovf;
            if (in_last) begin
                carry_d  = 1'b0;
                cnt_d    = '0;
                sticky_d = 1'b0;
                state_d  = IDLE;
`ifdef XS3_CARRY_DIGIT_EN
                if (cout) begin
                    out_last_d  = 1'b0;
                    out_carry_d = 1'b0;
                    err_d       = 1'b0;
                    ovf_d       = 1'b0;
                    pend_err_d  = sticky_q || cur_err;
                    pend_ovf_d  = num_ovf;
                    state_d     = CDIG;
                end
`endif
            end else begin
                carry_d  = cout;
                cnt_d    = cnt_inc;
                sticky_d = sticky_q || cur_err;
                state_d  = RUN;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_sum_q   <= 4'b0011;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
`ifdef XS3_CARRY_DIGIT_EN
            pend_err_q  <= 1'b0;
            pend_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
`ifdef XS3_CARRY_DIGIT_EN
            pend_err_q  <= pend_err_d;
            pend_ovf_q  <= pend_ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_xs3_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_xs3_serial_adder
//
// Randomized and directed stimulus for xs3_serial_adder. A behavioural model
// evaluates each accepted digit pair with plain integer arithmetic and pushes
// the expected output beat into exp_q; a negedge monitor pops and compares
// every output transfer, checks in_ready and output stability under stall.
// Beat packing in exp_q: {ovf, err, carry, last, sum[3:0]}.
// ---------------------------------------------------------------------------
module tb_xs3_serial_adder;

    localparam int NDIG = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_last;
    logic       out_carry;
    logic       err;
    logic       ovf;

    int tests_run = 0;
    int tests_failed = 0;

    xs3_serial_adder #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_carry (out_carry),
        .err       (err),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int  m_carry = 0;
    int  m_count = 0;
    bit  m_err = 0;
    bit  cdig_busy = 0;
    logic [7:0] extra_tag_q[$];  // 1 when the matching exp_q entry is an extra digit

    function automatic bit is_bad(input int c);
        return (c < 3) || (c > 12);
    endfunction

    task automatic model_accept(input int a, input int b, input bit last);
        int  tt;
        bit  co;
        int  s;
        bit  e;
        bit  o;
        tt = a + b + m_carry;
        co = (tt >= 16);
        s  = co ? ((tt - 16 + 3) % 16) : ((tt + 16 - 3) % 16);
        m_count++;
        e = m_err || is_bad(a) || is_bad(b);
        if (!last) begin
            exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 4'(s)});
            extra_tag_q.push_back(8'd0);
            m_carry = co;
            m_err   = e;
        end else begin
            o = (m_count > NDIG);
`ifdef XS3_CARRY_DIGIT_EN
            if (co) begin
                exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 4'(s)});
                extra_tag_q.push_back(8'd0);
                exp_q.push_back({o, e, 1'b0, 1'b1, 4'd4});
                extra_tag_q.push_back(8'd1);
                cdig_busy = 1;
            end else begin
                exp_q.push_back({o, e, 1'b0, 1'b1, 4'(s)});
                extra_tag_q.push_back(8'd0);
            end
`else
            exp_q.push_back({o, e, co, 1'b1, 4'(s)});
            extra_tag_q.push_back(8'd0);
`endif
            m_carry = 0;
            m_count = 0;
            m_err   = 0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         hold_prev = 0;
    logic [8:0] prev_out;

    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] want;
        logic [7:0] tag;
        if (!rst_n) begin
            exp_q.delete();
            extra_tag_q.delete();
            m_carry   = 0;
            m_count   = 0;
            m_err     = 0;
            cdig_busy = 0;
            hold_prev = 0;
        end else begin
            check_eq("in_ready", in_ready, !cdig_busy && (!out_valid || out_ready));
            if (hold_prev)
                check_eq("stall_stable", {out_valid, ovf, err, out_carry, out_last, out_sum}, prev_out);
            if (out_valid && out_ready) begin
                got = {ovf, err, out_carry & out_last, out_last, out_sum};
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", got, 8'hff);
                end else begin
                    want = exp_q.pop_front();
                    tag  = extra_tag_q.pop_front();
                    check_eq("out_beat", got, want);
                    if (tag == 8'd1) cdig_busy = 0;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = {out_valid, ovf, err, out_carry, out_last, out_sum};
            if (in_valid && in_ready) model_accept(int'(in_a), int'(in_b), in_last);
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: manual
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- input driver ----------------
    bit gaps = 0;
    logic [3:0] num_a[16];
    logic [3:0] num_b[16];

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic last);
        bit got_it;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                in_a = 4'($urandom);
                in_b = 4'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        got_it   = 0;
        for (int k = 0; k < 200 && !got_it; k++) begin
            @(negedge clk);
            if (in_ready) got_it = 1;
            @(posedge clk);
            #1;
        end
        if (!got_it) check_eq("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = 4'($urandom);
        in_b     = 4'($urandom);
    endtask

    task automatic send_number(input int n);
        for (int i = 0; i < n; i++)
            send_beat(num_a[i], num_b[i], (i == n - 1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [3:0] rand_code();
        if ($urandom_range(0, 9) == 0) return 4'($urandom);
        return 4'($urandom_range(3, 12));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum", out_sum, 4'b0011);
        check_eq("rst_flags", {out_last, out_carry, err, ovf}, 4'b0000);
        rst_n = 1'b1;

        // Single digit 5 + 4 = 9, visible one cycle after acceptance.
        send_beat(4'b1000, 4'b0111, 1'b1);
        check_eq("single_valid", out_valid, 1);
        check_eq("single_sum", out_sum, 4'b1100);
        check_eq("single_flags", {out_last, out_carry, err, ovf}, 4'b1000);
        drain();

        // 58 + 67 = 125.
        send_beat(4'b1011, 4'b1010, 1'b0);
        check_eq("two_dig_d0", out_sum, 4'b1000);
        send_beat(4'b1000, 4'b1001, 1'b1);
        check_eq("two_dig_d1", out_sum, 4'b0101);
        drain();

        // Backpressure: downstream stalls for 3 cycles while digits are offered.
        rdy_mode = 2;
        num_a[0] = 4'b1100; num_b[0] = 4'b1011;
        num_a[1] = 4'b0110; num_b[1] = 4'b1001;
        num_a[2] = 4'b0100; num_b[2] = 4'b0011;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            send_number(3);
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        rdy_mode = 0;
        drain();

        // Invalid code on digit 0, then a clean number.
        num_a[0] = 4'b0001; num_b[0] = 4'b0100;
        num_a[1] = 4'b0100; num_b[1] = 4'b0100;
        send_number(2);
        num_a[0] = 4'b0101; num_b[0] = 4'b0110;
        send_number(1);
        drain();

        // Overflow: five digits of 0 + 0.
        for (int i = 0; i < 5; i++) begin
            num_a[i] = 4'b0011;
            num_b[i] = 4'b0011;
        end
        send_number(5);
        drain();

        // Reset in the middle of a number with carry pending (9 + 9).
        send_beat(4'b1100, 4'b1100, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_sum", out_sum, 4'b0011);
        check_eq("midrst_flags", {out_last, out_carry, err, ovf}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        send_beat(4'b0011, 4'b0011, 1'b1);
        check_eq("post_rst_sum", out_sum, 4'b0011);
        check_eq("post_rst_carry", out_carry, 0);
        drain();

        // Random numbers, random gaps and random downstream stalls.
        rdy_mode = 1;
        gaps     = 1;
        for (int n = 0; n < 60; n++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                num_a[i] = rand_code();
                num_b[i] = rand_code();
            end
            send_number(len);
        end
        rdy_mode = 0;
        gaps     = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
